// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC bundle between the fetch control and pc_gen.
// slave = pc_gen (takes stall/redirects, drives pc/ce/sequential addrs).
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_address_i;
  logic              exc_flag_i;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic              pend_o;
  logic              misalign_o;

  modport master (
    output stall, branch_flag_i,
    output branch_target_address_i, exc_flag_i,
    input  pc, ce, pc_plus1, pc_plus2,
    input  pend_o, misalign_o
  );

  modport slave (
    input  stall, branch_flag_i,
    input  branch_target_address_i, exc_flag_i,
    output pc, ce, pc_plus1, pc_plus2,
    output pend_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with stall hold, branch/exception
// redirect, stalled-redirect buffering and misaligned-target flag.
// Ports: clk, rst (async, active-high), bus (pc_gen_if.slave):
//   stall/branch/target/exc in; pc, ce, pc_plus1/2, pend_o,
//   misalign_o out.
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter int INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(32'hBFC0_0000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR =
    ADDR_W'(32'hBFC0_0380)
) (
  input logic    clk,
  input logic    rst,
  pc_gen_if.slave bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] LOW  = ADDR_W'(INST_BYTES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              ce_q, ce_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] br_tgt;
  assign br_tgt = bus.branch_target_address_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    ce_d    = ce_q;
    mis_d   = 1'b0;
    case (state_q)
      S_BOOT: begin
        ce_d    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (bus.exc_flag_i) begin
          pc_d    = EXC_VECTOR;
          state_d = S_RUN;
        end else if (!bus.stall) begin
          if (bus.branch_flag_i) begin
            pc_d    = br_tgt & ~LOW;
            mis_d   = |(br_tgt & LOW);
            state_d = S_RUN;
          end else if (state_q == S_HOLD) begin
            pc_d    = tgt_q & ~LOW;
            mis_d   = |(tgt_q & LOW);
            state_d = S_RUN;
          end else begin
            pc_d = pc_q + STEP;
          end
        end else if (bus.branch_flag_i) begin
          // raw target kept so misalign is judged at load time
          tgt_d   = br_tgt;
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_BOOT;
        ce_d    = 1'b0;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ce_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ce_q    <= ce_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ce         = ce_q;
  assign bus.pc_plus1   = pc_q + STEP;
  assign bus.pc_plus2   = pc_q + (STEP << 1);
  assign bus.pend_o     = (state_q == S_HOLD);
  assign bus.misalign_o = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen, 32-bit default build
// plus a 16-bit/2-byte build for wraparound.
module tb_pc_gen;

  logic clk;
  logic rst;
  logic rst16;
  int   total;
  int   bad;
  int   step;

  pc_gen_if #(.ADDR_W(32)) b();
  pc_gen_if #(.ADDR_W(16)) h();

  pc_gen u0 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  pc_gen #(
    .ADDR_W     (16),
    .INST_BYTES (2),
    .RESET_PC   (16'hFFFC),
    .EXC_VECTOR (16'h0380)
  ) u1 (
    .clk (clk),
    .rst (rst16),
    .bus (h)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sb16[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h",
               tag, step, got, want);
    end
  endtask

  task automatic cyc(input logic st, input logic br,
                     input logic ex, input logic [31:0] tgt,
                     input logic [31:0] e_pc,
                     input logic e_pend, input logic e_mis);
    exp_t        e;
    logic [31:0] w1;
    logic [31:0] w2;
    b.stall = st;
    b.branch_flag_i = br;
    b.exc_flag_i = ex;
    b.branch_target_address_i = tgt;
    e.pc = e_pc;
    e.pend = e_pend;
    e.mis = e_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    b.stall = 1'b0;
    b.branch_flag_i = 1'b0;
    b.exc_flag_i = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      w1 = e.pc + 32'd4;
      w2 = e.pc + 32'd8;
      check("pc", b.pc, e.pc);
      check("ce", {31'd0, b.ce}, 32'd1);
      check("pend", {31'd0, b.pend_o}, {31'd0, e.pend});
      check("mis", {31'd0, b.misalign_o}, {31'd0, e.mis});
      check("p1", b.pc_plus1, w1);
      check("p2", b.pc_plus2, w2);
    end
  endtask

  task automatic cyc16(input logic [15:0] e_pc);
    logic [15:0] e;
    logic [15:0] w1;
    logic [15:0] w2;
    sb16.push_back(e_pc);
    @(posedge clk);
    #1;
    step++;
    if (sb16.size() == 0) begin
      check("sb16_empty", 32'd0, 32'd1);
    end else begin
      e = sb16.pop_front();
      w1 = e + 16'd2;
      w2 = e + 16'd4;
      check("pc16", {16'd0, h.pc}, {16'd0, e});
      check("ce16", {31'd0, h.ce}, 32'd1);
      check("p1_16", {16'd0, h.pc_plus1}, {16'd0, w1});
      check("p2_16", {16'd0, h.pc_plus2}, {16'd0, w2});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    step = 0;
    rst = 1'b1;
    rst16 = 1'b1;
    b.stall = 1'b0;
    b.branch_flag_i = 1'b0;
    b.exc_flag_i = 1'b0;
    b.branch_target_address_i = '0;
    h.stall = 1'b0;
    h.branch_flag_i = 1'b0;
    h.exc_flag_i = 1'b0;
    h.branch_target_address_i = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", b.pc, 32'hBFC0_0000);
    check("rst_ce", {31'd0, b.ce}, 32'd0);
    check("rst_pend", {31'd0, b.pend_o}, 32'd0);
    check("rst_mis", {31'd0, b.misalign_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("boot_ce", {31'd0, b.ce}, 32'd0);
    check("boot_pc", b.pc, 32'hBFC0_0000);

    // boot and sequential fetch
    cyc(0, 0, 0, 32'h0, 32'hBFC0_0000, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'hBFC0_0004, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'hBFC0_0008, 0, 0);
    // direct branches
    cyc(0, 1, 0, 32'h8000_0010, 32'h8000_0010, 0, 0);
    cyc(0, 1, 0, 32'h8000_1000, 32'h8000_1000, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'h8000_1004, 0, 0);
    // branches during stall, newest wins
    cyc(0, 1, 0, 32'h8000_0020, 32'h8000_0020, 0, 0);
    cyc(1, 1, 0, 32'h8000_2000, 32'h8000_0020, 1, 0);
    cyc(1, 1, 0, 32'h8000_3000, 32'h8000_0020, 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h8000_0020, 1, 0);
    cyc(0, 0, 0, 32'h0, 32'h8000_3000, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'h8000_3004, 0, 0);
    // exception + branch while stalled with pending target
    cyc(1, 1, 0, 32'h8000_4000, 32'h8000_3004, 1, 0);
    cyc(1, 1, 1, 32'h8000_5001, 32'hBFC0_0380, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'hBFC0_0384, 0, 0);
    // misaligned direct and pending targets
    cyc(0, 1, 0, 32'h8000_0102, 32'h8000_0100, 0, 1);
    cyc(0, 0, 0, 32'h0, 32'h8000_0104, 0, 0);
    cyc(1, 1, 0, 32'h8000_0206, 32'h8000_0104, 1, 0);
    cyc(0, 0, 0, 32'h0, 32'h8000_0204, 0, 1);
    cyc(0, 0, 0, 32'h0, 32'h8000_0208, 0, 0);
    // exception beats misaligned branch, unstalled
    cyc(0, 1, 1, 32'h8000_0302, 32'hBFC0_0380, 0, 0);
    // 32-bit wraparound
    cyc(0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 0, 32'h0, 32'h0000_0000, 0, 0);
    // async reset in HOLD
    cyc(1, 1, 0, 32'h8000_0400, 32'h0000_0000, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_pc", b.pc, 32'hBFC0_0000);
    check("arst_ce", {31'd0, b.ce}, 32'd0);
    check("arst_pend", {31'd0, b.pend_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rst16 = 1'b0;

    // 16-bit build wraps FFFE -> 0000
    cyc16(16'hFFFC);
    cyc16(16'hFFFE);
    cyc16(16'h0000);
    cyc16(16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
